// File: rtl/rv32i_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, ALU ops, FSM states, mux selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

  // Major opcodes recognised by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Shared ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_EQ  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BRANCH,
    S_HALT
  } state_t;

  // Immediate format is a pure function of the opcode, independent of FSM state
  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    logic [1:0] sel;
    sel = IMM_I;
    case (opcode)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multi-cycle controller and its datapath: instruction fields and flags in, controls out.
// Latency: n/a (wiring only).
// Backpressure: mem_ready is the only stall input; the controller holds its outputs while it is low.
interface multicycle_ctrl_if;

  // Datapath -> controller
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       alu_flag;
  logic       mem_ready;

  // Controller -> datapath
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_op;
  logic       halted;

  modport master (
    input  opcode, funct3, funct7b5, alu_flag, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write,
    output result_src, alu_src_a, alu_src_b, imm_src, alu_op, halted
  );

  modport slave (
    output opcode, funct3, funct7b5, alu_flag, mem_ready,
    input  pc_write, ir_write, adr_src, mem_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, imm_src, alu_op, halted
  );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps funct3/funct7b5 of an R- or I-type ALU instruction onto the shared ALU op code, flagging unsupported ops.
// Latency: combinational.
// Backpressure: none.
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_op,
  output logic       illegal
);

  // funct7b5 only selects sub for R-type; addi has immediate bits there
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct3)
      3'b000:  alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b010:  alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the shared ALU through fetch/decode/execute/writeback for the RV32I datapath.
// Latency: 3 cycles (branch) to 5 cycles (load) per instruction plus memory wait cycles.
// Backpressure: stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; halts after MEM_WAIT_MAX waits (0 = unbounded).
// Optional: define CTRL_BRANCH_EXT_EN to accept bne/blt/bge in addition to beq.
module multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  // Wait counter counts 0..MEM_WAIT_MAX-1; the timeout fires on the last of those cycles
  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt;
  logic            wait_state;
  logic            timeout;

  logic            pc_w, ir_w, mem_w, reg_w;
  logic            adr_sel;
  logic [1:0]      res_sel, a_sel, b_sel;
  logic [2:0]      aop;
  logic            halt_o;

  logic [2:0]      dec_op;
  logic            dec_illegal;
  logic [2:0]      br_op;
  logic            br_legal;
  logic            br_invert;

  alu_decoder u_alu_decoder (
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .is_rtype (state_q == S_EXECR),
    .alu_op   (dec_op),
    .illegal  (dec_illegal)
  );

  // Branch flavour: which compare to run and whether the taken sense is inverted
  always_comb begin
    br_legal  = 1'b0;
    br_op     = ALU_EQ;
    br_invert = 1'b0;
    case (bus.funct3)
      3'b000: br_legal = 1'b1;
`ifdef CTRL_BRANCH_EXT_EN
      3'b001: begin br_legal = 1'b1; br_invert = 1'b1; end
      3'b100: begin br_legal = 1'b1; br_op = ALU_SLT; end
      3'b101: begin br_legal = 1'b1; br_op = ALU_SLT; br_invert = 1'b1; end
`endif
      default: br_legal = 1'b0;
    endcase
  end

  // Memory-facing states are the only ones that may stall
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  // A ready on the limit cycle wins, so the timeout needs mem_ready low
  assign timeout = (MEM_WAIT_MAX != 0) && wait_state && !bus.mem_ready &&
                   (wait_cnt == CW'(MEM_WAIT_MAX - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Stall cycle counter, cleared whenever the FSM moves on
  always_ff @(posedge clk) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (state_d != state_q)
      wait_cnt <= '0;
    else if ((MEM_WAIT_MAX != 0) && wait_state && !bus.mem_ready)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Next state and per-state control outputs
  always_comb begin
    state_d = state_q;
    pc_w    = 1'b0;
    ir_w    = 1'b0;
    mem_w   = 1'b0;
    reg_w   = 1'b0;
    adr_sel = 1'b0;
    res_sel = RES_ALUOUT;
    a_sel   = SRCA_PC;
    b_sel   = SRCB_RS2;
    aop     = ALU_ADD;
    halt_o  = 1'b0;
    case (state_q)
      S_FETCH: begin
        a_sel   = SRCA_PC;
        b_sel   = SRCB_FOUR;
        res_sel = RES_ALU;
        ir_w    = bus.mem_ready;
        pc_w    = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
        else if (timeout)  state_d = S_HALT;
      end
      S_DECODE: begin
        // Branch/jal target lands in ALUOut while the opcode is being dispatched
        a_sel = SRCA_OLDPC;
        b_sel = SRCB_IMM;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        a_sel   = SRCA_RS1;
        b_sel   = SRCB_IMM;
        state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_sel = 1'b1;
        res_sel = RES_ALUOUT;
        if (bus.mem_ready) state_d = S_MEMWB;
        else if (timeout)  state_d = S_HALT;
      end
      S_MEMWB: begin
        res_sel = RES_MEM;
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_sel = 1'b1;
        res_sel = RES_ALUOUT;
        mem_w   = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else if (timeout)  state_d = S_HALT;
      end
      S_EXECR, S_EXECI: begin
        a_sel   = SRCA_RS1;
        b_sel   = (state_q == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
        aop     = dec_op;
        state_d = dec_illegal ? S_HALT : S_ALUWB;
      end
      S_ALUWB: begin
        res_sel = RES_ALUOUT;
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // Jump to the target from DECODE while the ALU forms old PC + 4 for rd
        a_sel   = SRCA_OLDPC;
        b_sel   = SRCB_FOUR;
        res_sel = RES_ALUOUT;
        pc_w    = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        a_sel   = SRCA_RS1;
        b_sel   = SRCB_RS2;
        res_sel = RES_ALUOUT;
        aop     = br_op;
        pc_w    = br_legal && (bus.alu_flag ^ br_invert);
        state_d = br_legal ? S_FETCH : S_HALT;
      end
      S_HALT: begin
        halt_o = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Write enables are forced low while reset is held so nothing commits mid-reset
  assign bus.pc_write   = rst_n & pc_w;
  assign bus.ir_write   = rst_n & ir_w;
  assign bus.mem_write  = rst_n & mem_w;
  assign bus.reg_write  = rst_n & reg_w;
  assign bus.adr_src    = adr_sel;
  assign bus.result_src = res_sel;
  assign bus.alu_src_a  = a_sel;
  assign bus.alu_src_b  = b_sel;
  assign bus.alu_op     = aop;
  assign bus.imm_src    = imm_src_of(bus.opcode);
  assign bus.halted     = halt_o;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected output trace built from the instruction-level rules.
// Latency: n/a.
// Backpressure: mem_ready stalls are scripted per trace step.
module tb_multicycle_ctrl;

  localparam int MAXW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int failures = 0;

  // {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, src_a, src_b, imm_src, alu_op, halted}
  logic [16:0] obs;
  assign obs = {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_op, bus.halted};

  typedef struct {
    logic        mr;
    logic [16:0] v;
  } step_t;

  step_t q[$];
  logic [6:0] c_op;
  logic [2:0] c_f3;
  logic       c_f7;
  logic       c_flag;
  logic [1:0] c_im;
  bit         exp_halt;

  function automatic logic [16:0] pk(input logic pcw, input logic irw, input logic adr,
                                     input logic mw, input logic rw, input logic [1:0] res,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] im, input logic [2:0] op, input logic h);
    return {pcw, irw, adr, mw, rw, res, sa, sb, im, op, h};
  endfunction

  function automatic logic [1:0] imm_exp(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic [16:0] v);
    step_t s;
    s.mr = mr;
    s.v  = v;
    q.push_back(s);
  endtask

  task automatic halt_tail();
    exp_halt = 1'b1;
    for (int i = 0; i < 3; i++) push(rbit(), pk(0,0,0,0,0,2'b00,2'b00,2'b00,c_im,3'b000,1));
  endtask

  // A memory-facing phase: 'w' stalled cycles then a ready cycle, or a timeout after MAXW stalls
  task automatic mem_phase(input int w, input logic [16:0] stall_v, input logic [16:0] ready_v, output bit to);
    int n;
    n = (w < MAXW) ? w : MAXW;
    for (int i = 0; i < n; i++) push(1'b0, stall_v);
    to = (w >= MAXW);
    if (!to) push(1'b1, ready_v);
  endtask

  // Expected cycle-by-cycle trace for one instruction, straight from the instruction rules
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic flag, input int wf, input int wm);
    bit to, legal, taken, is_r;
    logic [2:0] code;
    q.delete();
    exp_halt = 1'b0;
    c_op = op; c_f3 = f3; c_f7 = f7; c_flag = flag; c_im = imm_exp(op);
    mem_phase(wf, pk(0,0,0,0,0,2'b10,2'b00,2'b10,c_im,3'b000,0),
                  pk(1,1,0,0,0,2'b10,2'b00,2'b10,c_im,3'b000,0), to);
    if (to) begin halt_tail(); return; end
    push(rbit(), pk(0,0,0,0,0,2'b00,2'b01,2'b01,c_im,3'b000,0));
    case (op)
      7'b0000011, 7'b0100011: begin
        logic mw;
        mw = (op == 7'b0100011);
        push(rbit(), pk(0,0,0,0,0,2'b00,2'b10,2'b01,c_im,3'b000,0));
        mem_phase(wm, pk(0,0,1,mw,0,2'b00,2'b00,2'b00,c_im,3'b000,0),
                      pk(0,0,1,mw,0,2'b00,2'b00,2'b00,c_im,3'b000,0), to);
        if (to) begin halt_tail(); return; end
        if (!mw) push(rbit(), pk(0,0,0,0,1,2'b01,2'b00,2'b00,c_im,3'b000,0));
      end
      7'b0110011, 7'b0010011: begin
        is_r = (op == 7'b0110011);
        legal = 1'b1;
        code = 3'b000;
        case (f3)
          3'd0:    code = (is_r && f7) ? 3'b001 : 3'b000;
          3'd7:    code = 3'b010;
          3'd6:    code = 3'b011;
          3'd2:    code = 3'b101;
          default: legal = 1'b0;
        endcase
        push(rbit(), pk(0,0,0,0,0,2'b00,2'b10, is_r ? 2'b00 : 2'b01, c_im, code, 0));
        if (!legal) begin halt_tail(); return; end
        push(rbit(), pk(0,0,0,0,1,2'b00,2'b00,2'b00,c_im,3'b000,0));
      end
      7'b1101111: begin
        push(rbit(), pk(1,0,0,0,0,2'b00,2'b01,2'b10,c_im,3'b000,0));
        push(rbit(), pk(0,0,0,0,1,2'b00,2'b00,2'b00,c_im,3'b000,0));
      end
      7'b1100011: begin
        legal = 1'b0; code = 3'b100; taken = 1'b0;
        if (f3 == 3'd0) begin legal = 1'b1; taken = flag; end
`ifdef CTRL_BRANCH_EXT_EN
        if (f3 == 3'd1) begin legal = 1'b1; taken = !flag; end
        if (f3 == 3'd4) begin legal = 1'b1; code = 3'b101; taken = flag; end
        if (f3 == 3'd5) begin legal = 1'b1; code = 3'b101; taken = !flag; end
`endif
        push(rbit(), pk(legal && taken,0,0,0,0,2'b00,2'b10,2'b00,c_im,code,0));
        if (!legal) begin halt_tail(); return; end
      end
      default: halt_tail();
    endcase
  endtask

  task automatic check(input string tag, input int step, input logic [16:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s step%0d observed=%h expected=%h", tag, step, obs, expv);
    end
  endtask

  // Replay the trace: inputs change on the falling edge, outputs sampled 1 time unit later
  task automatic run(input string tag, input int limit);
    int n;
    n = (limit < q.size()) ? limit : q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (i == 0) begin
        bus.opcode = c_op; bus.funct3 = c_f3; bus.funct7b5 = c_f7; bus.alu_flag = c_flag;
      end
      bus.mem_ready = q[i].mr;
      #1;
      check(tag, i, q[i].v);
    end
  endtask

  // Two cycles of reset: enables must read 0 throughout, and the FSM must sit in FETCH after the first edge
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    assert ({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write} === 4'b0000) else begin
      failures++;
      $error("FAIL rst_enables observed=%b expected=0000",
             {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write});
    end
    @(negedge clk);
    #1;
    check("rst_fetch", 0, pk(0,0,0,0,0,2'b10,2'b00,2'b10,imm_exp(bus.opcode),3'b000,0));
  endtask

  function automatic int rwait();
    if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 3));
    return int'($urandom_range(14, 17));
  endfunction

  initial begin
    bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.alu_flag = 1'b0; bus.mem_ready = 1'b0;
    do_reset();

    // Store interrupted mid-MEMWRITE by reset
    build(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 10);
    run("sw_abort", 6);
    do_reset();

    // sub
    build(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);  run("sub", 99);
    // lw with 3-cycle memory stall
    build(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);  run("lw_wait3", 99);
    // beq taken / not taken
    build(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);  run("beq_t", 99);
    build(7'b1100011, 3'b000, 1'b0, 1'b0, 1, 0);  run("beq_nt", 99);
    // bne: legal only with the branch extension
    build(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);  run("bne", 99);
    if (exp_halt) do_reset();
    // addi ignores funct7b5; jal
    build(7'b0010011, 3'b000, 1'b1, 1'b0, 2, 0);  run("addi", 99);
    build(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);  run("jal", 99);
    // lui is unsupported
    build(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0);  run("lui_halt", 99);
    do_reset();
    // fetch stall boundaries: ready on the last allowed cycle, then a full timeout
    build(7'b0110011, 3'b111, 1'b0, 1'b0, MAXW - 1, 0);  run("fetch_wait15", 99);
    build(7'b0110011, 3'b111, 1'b0, 1'b0, MAXW, 0);      run("fetch_timeout", 99);
    do_reset();
    // store timeout in MEMWRITE
    build(7'b0100011, 3'b010, 1'b0, 1'b0, 0, MAXW);      run("sw_timeout", 99);
    do_reset();

    // Randomized instruction mix
    for (int k = 0; k < 60; k++) begin
      logic [6:0] op;
      case ($urandom_range(0, 7))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1101111;
        5: op = 7'b1100011;
        6: op = 7'b0110111;
        default: op = 7'($urandom_range(0, 127));
      endcase
      build(op, 3'($urandom_range(0, 7)), rbit(), rbit(), rwait(), rwait());
      run("rand", 999);
      if (exp_halt) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
